// File: rtl/line_addr_gen_pkg.sv
// Shared widths, derived constants and state type for the cache-line burst address generator.
package line_addr_gen_pkg;

  localparam int unsigned ADDRESS_BITS       = 32;
  localparam int unsigned OFFSET_BITS        = 6;
  localparam int unsigned INDEX_BITS         = 14;
  localparam int unsigned TAG_BITS           = 12;
  localparam int unsigned DEFAULT_WORD_BYTES = 4;

  // Word-select field width; kept at least one bit wide so ports never collapse to zero width.
  localparam int unsigned WSEL_BITS = OFFSET_BITS - $clog2(DEFAULT_WORD_BYTES);
  localparam int unsigned WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;

  typedef enum logic [0:0] {
    IDLE,
    BURST
  } line_state_e;

  function automatic int unsigned beats_per_line(input int unsigned wsel_bits);
    return 32'd1 << wsel_bits;
  endfunction

endpackage

// File: rtl/line_addr_gen_if.sv
// Request and bus-beat signals between a line requester/consumer and the burst address generator.
interface line_addr_gen_if;
  import line_addr_gen_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_index;
  logic                    req_write;
  logic [WSEL_W-1:0]       req_word;

  logic                    bus_valid;
  logic                    bus_ready;
  logic [ADDRESS_BITS-1:0] bus_addr;
  logic                    bus_write;
  logic                    bus_last;
  logic                    done;

  // Generator side.
  modport slave (
    input  req_valid, req_tag, req_index, req_write, req_word, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_write, bus_last, done
  );

  // Requester / downstream side.
  modport master (
    output req_valid, req_tag, req_index, req_write, req_word, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_write, bus_last, done
  );

endinterface

// File: rtl/line_addr_gen_address_compose.sv
// Rebuilds a word-aligned byte address from tag, index and word fields; mirror of the address split.
module address_compose
  import line_addr_gen_pkg::*;
#(
  parameter int unsigned WordBytes = DEFAULT_WORD_BYTES
) (
  input  logic [TAG_BITS-1:0]     tag_i,
  input  logic [INDEX_BITS-1:0]   index_i,
  input  logic [WSEL_W-1:0]       word_i,
  output logic [ADDRESS_BITS-1:0] addr_o
);

  localparam int unsigned ByteBits = $clog2(WordBytes);
  localparam int unsigned WselBits = OFFSET_BITS - ByteBits;

  logic [ADDRESS_BITS-1:0] line_base;
  logic [ADDRESS_BITS-1:0] word_off;

  // Fields occupy disjoint bit ranges, so OR-ing them is a pure concatenation with no carry.
  always_comb begin
    line_base = ADDRESS_BITS'({tag_i, index_i}) << OFFSET_BITS;
  end

  if (WselBits > 0) begin : g_word
    always_comb begin
      word_off = ADDRESS_BITS'(word_i[WselBits-1:0]) << ByteBits;
    end
  end else begin : g_no_word
    always_comb begin
      word_off = '0;
    end
  end

  always_comb begin
    addr_o = line_base | word_off;
  end

endmodule

// File: rtl/line_addr_gen.sv
// Burst address generator: walks every word of a cache line, critical word first for fills.
module line_addr_gen
  import line_addr_gen_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input logic           clk,
  input logic           rst_n,
  line_addr_gen_if.slave lag
);

  localparam int unsigned WselBits = OFFSET_BITS - $clog2(WORD_BYTES);
  localparam int unsigned WselW    = (WselBits > 0) ? WselBits : 1;
  localparam int unsigned Beats    = beats_per_line(WselBits);
  localparam logic [WselW-1:0] LastBeat = WselW'(Beats - 1);

  line_state_e             state_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic [INDEX_BITS-1:0]   index_q;
  logic                    write_q;
  logic [WselW-1:0]        word_q;
  logic [WselW-1:0]        beat_q;
  logic                    done_q;
  logic [WSEL_W-1:0]       word_addr;
  logic [ADDRESS_BITS-1:0] addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      write_q <= 1'b0;
      word_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lag.req_valid) begin
            tag_q   <= lag.req_tag;
            index_q <= lag.req_index;
            write_q <= lag.req_write;
            // Writebacks always stream the line in order from word 0.
            word_q  <= lag.req_write ? '0 : lag.req_word[WselW-1:0];
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (lag.bus_ready) begin
            if (beat_q == LastBeat) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
              // Natural overflow gives the wrap from the last word back to word 0.
              word_q <= word_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    word_addr            = '0;
    word_addr[WselW-1:0] = word_q;
  end

  address_compose #(
    .WordBytes (WORD_BYTES)
  ) u_address_compose (
    .tag_i   (tag_q),
    .index_i (index_q),
    .word_i  (word_addr),
    .addr_o  (addr)
  );

  always_comb begin
    lag.req_ready = (state_q == IDLE);
    lag.bus_valid = (state_q == BURST);
    lag.bus_last  = (state_q == BURST) && (beat_q == LastBeat);
    lag.bus_addr  = addr;
    lag.bus_write = write_q;
    lag.done      = done_q;
  end

endmodule

// File: tb/tb_line_addr_gen.sv
// Self-checking bench for line_addr_gen: table of known lines, chained and reset corner cases, random lines.
module tb_line_addr_gen;
  import line_addr_gen_pkg::*;

  localparam int NumBeats = 16;

  typedef struct {
    logic [11:0] tag;
    logic [13:0] idx;
    logic        wr;
    logic [3:0]  word;
    bit          rnd;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  line_addr_gen_if lag_if ();

  line_addr_gen #(
    .WORD_BYTES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lag   (lag_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Address of word w of the line: tag above index above word above two zero byte bits.
  function automatic logic [31:0] ref_addr(input int unsigned tag, input int unsigned idx,
                                           input int unsigned w);
    return 32'(tag * 32'h0010_0000 + idx * 64 + (w % NumBeats) * 4);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(lag_if.req_ready), 32'd1);
    check({tag, "_bus_valid"}, 32'(lag_if.bus_valid), 32'd0);
    check({tag, "_bus_addr"},  lag_if.bus_addr,       32'd0);
    check({tag, "_bus_write"}, 32'(lag_if.bus_write), 32'd0);
    check({tag, "_bus_last"},  32'(lag_if.bus_last),  32'd0);
    check({tag, "_done"},      32'(lag_if.done),      32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done should be high.
  task automatic run_burst(input logic [11:0] tag, input logic [13:0] idx, input logic wr,
                           input logic [3:0] word, input bit rand_ready, input bit chain,
                           input logic [11:0] ntag, input logic [13:0] nidx, input logic nwr,
                           input logic [3:0] nword, output logic [31:0] first_a,
                           output logic [31:0] last_a);
    logic [31:0] exp_q[$];
    logic [31:0] prev_a;
    int          start;
    int          cycles;
    int          hs;
    bit          stalled;
    first_a = '0;
    last_a  = '0;
    prev_a  = '0;
    start   = wr ? 0 : int'(word);
    for (int b = 0; b < NumBeats; b++) exp_q.push_back(ref_addr(tag, idx, start + b));
    check("accept_ready", 32'(lag_if.req_ready), 32'd1);
    lag_if.req_valid = 1'b1;
    lag_if.req_tag   = tag;
    lag_if.req_index = idx;
    lag_if.req_write = wr;
    lag_if.req_word  = word;
    @(negedge clk);
    if (chain) begin
      lag_if.req_tag   = ntag;
      lag_if.req_index = nidx;
      lag_if.req_write = nwr;
      lag_if.req_word  = nword;
    end else begin
      lag_if.req_valid = 1'b0;
    end
    cycles  = 0;
    hs      = 0;
    stalled = 1'b0;
    while (exp_q.size() > 0 && cycles < 400) begin
      cycles++;
      check("bus_valid", 32'(lag_if.bus_valid), 32'd1);
      check("req_ready_busy", 32'(lag_if.req_ready), 32'd0);
      check("bus_write", 32'(lag_if.bus_write), 32'(wr));
      check("bus_addr", lag_if.bus_addr, exp_q[0]);
      check("bus_last", 32'(lag_if.bus_last), 32'(exp_q.size() == 1));
      check("done_busy", 32'(lag_if.done), 32'd0);
      if (stalled) check("stall_stable", lag_if.bus_addr, prev_a);
      prev_a           = lag_if.bus_addr;
      lag_if.bus_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (lag_if.bus_ready) begin
        if (hs == 0) first_a = lag_if.bus_addr;
        last_a = lag_if.bus_addr;
        void'(exp_q.pop_front());
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      @(negedge clk);
    end
    lag_if.bus_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    check("handshakes", 32'(hs), 32'(NumBeats));
    if (!rand_ready) check("burst_cycles", 32'(cycles), 32'(NumBeats));
    check("done_pulse", 32'(lag_if.done), 32'd1);
    check("ready_back", 32'(lag_if.req_ready), 32'd1);
    check("idle_gap", 32'(lag_if.bus_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] fa;
    logic [31:0] la;
    lag_if.req_valid = 1'b0;
    lag_if.req_tag   = '0;
    lag_if.req_index = '0;
    lag_if.req_write = 1'b0;
    lag_if.req_word  = '0;
    lag_if.bus_ready = 1'b0;

    vecs[0] = '{12'hABC, 14'h0012, 1'b1, 4'd0,  1'b0, 32'hABC0_0480, 32'hABC0_04BC};
    vecs[1] = '{12'hABC, 14'h0012, 1'b0, 4'd13, 1'b0, 32'hABC0_04B4, 32'hABC0_04B0};
    vecs[2] = '{12'hABC, 14'h0012, 1'b1, 4'd9,  1'b1, 32'hABC0_0480, 32'hABC0_04BC};
    vecs[3] = '{12'hFFF, 14'h3FFF, 1'b0, 4'd15, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    vecs[4] = '{12'h000, 14'h0000, 1'b0, 4'd0,  1'b0, 32'h0000_0000, 32'h0000_003C};
    vecs[5] = '{12'h001, 14'h0001, 1'b0, 4'd1,  1'b1, 32'h0010_0044, 32'h0010_0040};

    // Reset before any clock edge and while held low.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst_pre_clk");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_burst(vecs[i].tag, vecs[i].idx, vecs[i].wr, vecs[i].word, vecs[i].rnd, 1'b0,
                '0, '0, 1'b0, '0, fa, la);
      check($sformatf("vec%0d_first", i), fa, vecs[i].exp_first);
      check($sformatf("vec%0d_last", i), la, vecs[i].exp_last);
      @(negedge clk);
      check($sformatf("vec%0d_done_once", i), 32'(lag_if.done), 32'd0);
    end

    // Request held through a burst with different fields: ignored until done, then accepted.
    run_burst(12'h5A5, 14'h1234, 1'b0, 4'd6, 1'b0, 1'b1, 12'h3C3, 14'h0777, 1'b1, 4'd11, fa, la);
    run_burst(12'h3C3, 14'h0777, 1'b1, 4'd11, 1'b1, 1'b0, '0, '0, 1'b0, '0, fa, la);
    check("chain2_first", fa, 32'h3C31_DDC0);
    @(negedge clk);
    check("chain_done_once", 32'(lag_if.done), 32'd0);

    // Reset asserted at beat 5 of a fill.
    lag_if.req_valid = 1'b1;
    lag_if.req_tag   = 12'h123;
    lag_if.req_index = 14'h0456;
    lag_if.req_write = 1'b0;
    lag_if.req_word  = 4'd7;
    lag_if.bus_ready = 1'b1;
    @(negedge clk);
    lag_if.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("beat5_addr", lag_if.bus_addr, ref_addr(12'h123, 14'h0456, 7 + 5));
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid_burst");
    lag_if.bus_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_released");
    run_burst(12'h123, 14'h0456, 1'b0, 4'd3, 1'b1, 1'b0, '0, '0, 1'b0, '0, fa, la);
    check("post_rst_first", fa, ref_addr(12'h123, 14'h0456, 3));
    @(negedge clk);

    // Random lines under random backpressure.
    for (int n = 0; n < 8; n++) begin
      logic [11:0] rt;
      logic [13:0] ri;
      logic        rw;
      logic [3:0]  rwd;
      rt  = 12'($urandom);
      ri  = 14'($urandom);
      rw  = 1'($urandom);
      rwd = 4'($urandom);
      run_burst(rt, ri, rw, rwd, 1'b1, 1'b0, '0, '0, 1'b0, '0, fa, la);
      check("rand_first", fa, ref_addr(rt, ri, rw ? 0 : int'(rwd)));
      check("rand_last", la, ref_addr(rt, ri, (rw ? 0 : int'(rwd)) + NumBeats - 1));
      @(negedge clk);
      check("rand_done_once", 32'(lag_if.done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_addr_gen.md
# line_addr_gen

Burst address generator for cache line transfers between the cache controller and the next memory level. It accepts a line request carrying a tag, an index, a direction (fill or writeback) and a critical-word select. It then emits one full-width, word-aligned bus address per beat until the whole line has been covered. It is the inverse of the address-split path: it rebuilds addresses from tag/index/offset fields rather than splitting them.

## Interface

Parameters:
- WORD_BYTES, 4: bytes per bus beat; power of two, ≤ 2**OFFSET_BITS
- ADDRESS_BITS, OFFSET_BITS, INDEX_BITS, TAG_BITS: taken from mypkg, not overridden locally

Ports:
- clk, input, 1: the only clock
- rst_n, input, 1: reset, asynchronous, active-low
- req_valid, input, 1: line request present
- req_ready, output, 1: block can accept a request
- req_tag, input, TAG_BITS: line tag
- req_index, input, INDEX_BITS: line set index
- req_write, input, 1: 1 = writeback (eviction), 0 = fill
- req_word, input, WSEL_BITS: critical word for fills; ignored for writebacks
- bus_valid, output, 1: bus_addr valid
- bus_ready, input, 1: downstream accepts beat
- bus_addr, output, ADDRESS_BITS: {tag, index, word, WORD_BYTES-aligned zero byte bits}
- bus_write, output, 1: direction of the current burst
- bus_last, output, 1: current beat is the final beat of the line
- done, output, 1: one-cycle pulse after the final beat handshake

## Operation

- Derived values:
  - WSEL_BITS = OFFSET_BITS − $clog2(WORD_BYTES)
  - BEATS = 2**WSEL_BITS
  - If WSEL_BITS = 0, BEATS = 1 and the word field is absent.
- States: IDLE and BURST.
- IDLE:
  - req_ready = 1 and bus_valid = 0.
  - On req_valid && req_ready, latch tag, index and write, and move to BURST.
  - The start word is req_word for a fill and 0 for a writeback.
  - Reset the beat counter to 0.
- BURST:
  - req_ready = 0 and bus_valid = 1.
  - The current word is (start + beat) mod BEATS. The wrap-around is natural WSEL_BITS-bit overflow.
  - bus_last = (beat == BEATS−1).
  - bus_addr, bus_write and bus_last stay stable while bus_valid && !bus_ready.
  - On bus_valid && bus_ready:
    - If !bus_last, increment beat.
    - If bus_last, go to IDLE and assert done on the next cycle.
- Byte bits below the word offset are always 0. Address fields are concatenated with no arithmetic carry into index or tag.
- req_valid while in BURST is ignored. The requester must hold its request until req_ready.
- req_word is ignored when req_write = 1.

## Timing

- Reset values: state IDLE, req_ready = 1, bus_valid = 0, bus_addr = 0, bus_write = 0, bus_last = 0, done = 0, internal registers 0.
- Asserting rst_n low mid-burst drops bus_valid asynchronously and discards the burst. No done is produced.
- A request accepted at edge N gives bus_valid = 1 from cycle N+1.
- With bus_ready held at 1, the line takes exactly BEATS cycles. The final handshake occurs at edge N+BEATS.
- done is high for exactly the cycle after the final handshake, and req_ready returns in that same cycle. Back-to-back requests therefore have one idle cycle between bursts.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* or bus_ready to any output.

## Structure

- mypkg gains:
  - a WORD_BYTES default constant
  - a WSEL_BITS derived constant
  - a line_state_e enum {IDLE, BURST}
- Sub-module address_compose: a combinational concatenation of tag, index and word into bus_addr. It is the mirror of the address-split block and can be reused by other requesters.

## Test plan

Bench config: ADDRESS_BITS 32, OFFSET_BITS 6, INDEX_BITS 14, TAG_BITS 12, WORD_BYTES 4, so BEATS = 16.

- Writeback: tag 0xABC, index 0x0012, bus_ready held at 1 → addresses 0xABC00480, 0xABC00484, …, 0xABC004BC; bus_last on beat 16 only; bus_write = 1; done pulses once; req_ready returns.
- Fill with req_word 13, same tag and index → words 13, 14, 15, 0, 1, …, 12; first addr 0xABC004B4; last addr 0xABC004B0 with bus_last = 1.
- Backpressure: bus_ready toggling randomly → bus_addr stable while stalled; exactly 16 handshakes; no skipped or duplicated words.
- req_valid held during BURST with different fields → ignored; the second request is accepted only after done, with one idle cycle between bursts.
- rst_n asserted low at beat 5 → bus_valid = 0 immediately, no done, req_ready = 1 after release; a new request then starts cleanly from its own start word.
- Reset check: all outputs at their reset values before the first clock edge and while rst_n = 0.
